// File: rtl/alu_pkg.sv
// Shared ALU control codes, shift op encoding and shift sequencer state encoding.
package alu_pkg;

   localparam logic [5:0] ALU_AND  = 6'h00;
   localparam logic [5:0] ALU_SLL1 = 6'h0A;
   localparam logic [5:0] ALU_SLL2 = 6'h0B;
   localparam logic [5:0] ALU_SLL8 = 6'h0C;
   localparam logic [5:0] ALU_SRL1 = 6'h0D;
   localparam logic [5:0] ALU_SRL2 = 6'h0E;
   localparam logic [5:0] ALU_SRL8 = 6'h0F;
   localparam logic [5:0] ALU_SRA1 = 6'h10;
   localparam logic [5:0] ALU_SRA2 = 6'h11;
   localparam logic [5:0] ALU_SRA8 = 6'h12;

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_SRA  = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/shift_step_sel.sv
// Picks the next shift step (largest nonzero counter first) and its ALU code.
// step_sel is one-hot: bit2 = by 8, bit1 = by 2, bit0 = by 1; all-zero when nothing is left.
module shift_step_sel
   import alu_pkg::*;
#(
   parameter int N8_W = 2
) (
   input  logic [1:0]      op_reg,
   input  logic [N8_W-1:0] n8,
   input  logic [1:0]      n2,
   input  logic            n1,
   output logic [5:0]      alu_ctrl,
   output logic [2:0]      step_sel
);

   // priority select of the largest remaining step, then map (op, step) to a code
   always_comb begin
      step_sel = 3'b000;
      alu_ctrl = ALU_AND;
      if (n8 != '0)      step_sel = 3'b100;
      else if (n2 != '0) step_sel = 3'b010;
      else if (n1)       step_sel = 3'b001;
      case (op_reg)
         OP_SLL: begin
            if (step_sel[2])      alu_ctrl = ALU_SLL8;
            else if (step_sel[1]) alu_ctrl = ALU_SLL2;
            else if (step_sel[0]) alu_ctrl = ALU_SLL1;
         end
         OP_SRL: begin
            if (step_sel[2])      alu_ctrl = ALU_SRL8;
            else if (step_sel[1]) alu_ctrl = ALU_SRL2;
            else if (step_sel[0]) alu_ctrl = ALU_SRL1;
         end
         OP_SRA: begin
            if (step_sel[2])      alu_ctrl = ALU_SRA8;
            else if (step_sel[1]) alu_ctrl = ALU_SRA2;
            else if (step_sel[0]) alu_ctrl = ALU_SRA1;
         end
         default: alu_ctrl = ALU_AND;
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle arbitrary-distance shifter built on an ALU that only shifts by 1, 2 or 8.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; ALU inputs released
//   ST_SHIFT | one ALU step per cycle, result fed back into acc
//   ST_DONE  | one-cycle done pulse, result = acc
module shift_sequencer
   import alu_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               flush,
   input  logic [1:0]         op,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [DATA_W-1:0]  operand,
   input  logic [DATA_W-1:0]  alu_result,
   output logic [DATA_W-1:0]  alu_a,
   output logic [5:0]         alu_ctrl,
   output logic               alu_sel,
   output logic               busy,
   output logic               done,
   output logic [DATA_W-1:0]  result
);

   localparam int N8_W = SHAMT_W - 3;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [1:0]        op_q, op_d;
   logic [N8_W-1:0]   n8_q, n8_d;
   logic [1:0]        n2_q, n2_d;
   logic              n1_q, n1_d;

   logic [5:0]        step_ctrl;
   logic [2:0]        step_sel;

   shift_step_sel #(.N8_W(N8_W)) u_step_sel (
      .op_reg   (op_q),
      .n8       (n8_q),
      .n2       (n2_q),
      .n1       (n1_q),
      .alu_ctrl (step_ctrl),
      .step_sel (step_sel)
   );

   // next-state, accumulator and step-counter update; flush aborts without touching acc
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      op_d    = op_q;
      n8_d    = n8_q;
      n2_d    = n2_q;
      n1_d    = n1_q;
      case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               acc_d = operand;
               op_d  = op;
               n8_d  = shamt[SHAMT_W-1:3];
               n2_d  = shamt[2:1];
               n1_d  = shamt[0];
               if (shamt == '0 || op == OP_RSVD) state_d = ST_DONE;
               else                              state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            acc_d = alu_result;
            if (step_sel[2])      n8_d = n8_q - N8_W'(1);
            else if (step_sel[1]) n2_d = n2_q - 2'd1;
            else if (step_sel[0]) n1_d = 1'b0;
            // an empty step_sel cannot happen from IDLE, but exits cleanly if it does
            if (n8_d == '0 && n2_d == '0 && !n1_d) state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      if (flush) begin
         state_d = ST_IDLE;
         acc_d   = acc_q;
         op_d    = op_q;
         n8_d    = n8_q;
         n2_d    = n2_q;
         n1_d    = n1_q;
      end
   end

   // state and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         op_q    <= '0;
         n8_q    <= '0;
         n2_q    <= '0;
         n1_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         op_q    <= op_d;
         n8_q    <= n8_d;
         n2_q    <= n2_d;
         n1_q    <= n1_d;
      end
   end

   // outputs decode registered state only, so nothing from the inputs reaches the ALU mux
   always_comb begin
      alu_a    = '0;
      alu_ctrl = ALU_AND;
      alu_sel  = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      result   = '0;
      case (state_q)
         ST_SHIFT: begin
            alu_a    = acc_q;
            alu_ctrl = step_ctrl;
            alu_sel  = 1'b1;
            busy     = 1'b1;
         end
         ST_DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            result = acc_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed plus randomized bench for shift_sequencer with a behavioural ALU and reference model.
module tb_shift_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        flush;
   logic [1:0]  op;
   logic [4:0]  shamt;
   logic [31:0] operand;
   logic [31:0] alu_result;
   logic [31:0] alu_a;
   logic [5:0]  alu_ctrl;
   logic        alu_sel;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   shift_sequencer #(.DATA_W(32), .SHAMT_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .flush      (flush),
      .op         (op),
      .shamt      (shamt),
      .operand    (operand),
      .alu_result (alu_result),
      .alu_a      (alu_a),
      .alu_ctrl   (alu_ctrl),
      .alu_sel    (alu_sel),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU: only the shift codes shift; anything else scrambles so misuse is visible
   always_comb begin
      case (alu_ctrl)
         6'h0A:   alu_result = alu_a << 1;
         6'h0B:   alu_result = alu_a << 2;
         6'h0C:   alu_result = alu_a << 8;
         6'h0D:   alu_result = alu_a >> 1;
         6'h0E:   alu_result = alu_a >> 2;
         6'h0F:   alu_result = alu_a >> 8;
         6'h10:   alu_result = 32'($signed(alu_a) >>> 1);
         6'h11:   alu_result = 32'($signed(alu_a) >>> 2);
         6'h12:   alu_result = 32'($signed(alu_a) >>> 8);
         default: alu_result = alu_a ^ 32'h5A5A5A5A;
      endcase
   end

   function automatic logic [31:0] ref_shift(input logic [1:0] o, input int amt, input logic [31:0] v);
      case (o)
         2'd0:    return v << amt;
         2'd1:    return v >> amt;
         2'd2:    return 32'($signed(v) >>> amt);
         default: return v;
      endcase
   endfunction

   function automatic logic [5:0] step_code(input logic [1:0] o, input int sz);
      logic [5:0] base;
      base = (o == 2'd0) ? 6'h0A : (o == 2'd1) ? 6'h0D : 6'h10;
      return base + ((sz == 8) ? 6'd2 : (sz == 2) ? 6'd1 : 6'd0);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // runs one operation and checks every cycle until one cycle after done;
   // pester keeps throwing random starts/operands at the block while it is busy
   task automatic do_op(input logic [1:0] o, input logic [4:0] s, input logic [31:0] v, input bit pester);
      int sizes[$];
      int steps;
      int cum;
      logic [31:0] exp_res;
      sizes = {};
      if (o != 2'd3) begin
         for (int i = 0; i < int'(s) / 8; i++)       sizes.push_back(8);
         for (int i = 0; i < (int'(s) % 8) / 2; i++) sizes.push_back(2);
         if (int'(s) % 2 == 1)                      sizes.push_back(1);
      end
      steps   = sizes.size();
      exp_res = ref_shift(o, int'(s), v);
      cum     = 0;
      @(negedge clk);
      op = o; shamt = s; operand = v; start = 1'b1;
      @(negedge clk);
      start = pester ? 1'b1 : 1'b0;
      if (pester) begin
         operand = $urandom; op = 2'($urandom_range(0, 3)); shamt = 5'($urandom_range(0, 31));
      end
      for (int c = 1; c <= steps + 2; c++) begin
         if (c <= steps) begin
            chk("shift_sel", 32'(alu_sel), 32'd1);
            chk("shift_busy", 32'(busy), 32'd1);
            chk("shift_done", 32'(done), 32'd0);
            chk("shift_ctrl", 32'(alu_ctrl), 32'(step_code(o, sizes[c-1])));
            chk("shift_alu_a", alu_a, ref_shift(o, cum, v));
            cum += sizes[c-1];
         end else if (c == steps + 1) begin
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_busy", 32'(busy), 32'd1);
            chk("done_sel", 32'(alu_sel), 32'd0);
            chk("done_ctrl", 32'(alu_ctrl), 32'd0);
            chk("done_result", result, exp_res);
            start = 1'b0;
         end else begin
            chk("after_busy", 32'(busy), 32'd0);
            chk("after_done", 32'(done), 32'd0);
            chk("after_sel", 32'(alu_sel), 32'd0);
         end
         if (pester && c < steps + 1) begin
            start = 1'($urandom_range(0, 1));
            operand = $urandom; op = 2'($urandom_range(0, 3)); shamt = 5'($urandom_range(0, 31));
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; flush = 1'b0; op = 2'd0; shamt = 5'd0; operand = 32'd0;
      repeat (2) @(negedge clk);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_ctrl", 32'(alu_ctrl), 32'd0);
      chk("rst_sel", 32'(alu_sel), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_result", result, 32'd0);
      reset = 1'b1;

      do_op(2'd0, 5'd13, 32'h00000001, 1'b0);
      do_op(2'd2, 5'd31, 32'h80000000, 1'b0);
      do_op(2'd1, 5'd31, 32'h80000000, 1'b0);
      do_op(2'd0, 5'd0,  32'hDEADBEEF, 1'b0);
      do_op(2'd3, 5'd13, 32'hDEADBEEF, 1'b0);

      // flush in the second SHIFT cycle aborts with no done pulse
      @(negedge clk);
      op = 2'd0; shamt = 5'd24; operand = 32'h00000003; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("fl_cyc1_sel", 32'(alu_sel), 32'd1);
      @(negedge clk);
      chk("fl_cyc2_sel", 32'(alu_sel), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fl_idle_busy", 32'(busy), 32'd0);
      chk("fl_idle_done", 32'(done), 32'd0);
      chk("fl_idle_sel", 32'(alu_sel), 32'd0);
      @(negedge clk);
      chk("fl_nodone", 32'(done), 32'd0);
      do_op(2'd0, 5'd24, 32'h00000003, 1'b0);

      // repeated starts while busy are ignored
      do_op(2'd1, 5'd9, 32'hF0000000, 1'b1);

      // reset low during SHIFT clears everything at that edge
      @(negedge clk);
      op = 2'd0; shamt = 5'd31; operand = 32'h12345679; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("rs_pre_busy", 32'(busy), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("rs_alu_a", alu_a, 32'd0);
      chk("rs_ctrl", 32'(alu_ctrl), 32'd0);
      chk("rs_sel", 32'(alu_sel), 32'd0);
      chk("rs_busy", 32'(busy), 32'd0);
      chk("rs_done", 32'(done), 32'd0);
      chk("rs_result", result, 32'd0);
      reset = 1'b1;

      // flush and start together in IDLE: flush wins
      @(negedge clk);
      op = 2'd0; shamt = 5'd5; operand = 32'h0000_00FF; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("fs_busy", 32'(busy), 32'd0);
      chk("fs_sel", 32'(alu_sel), 32'd0);
      chk("fs_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("fs_busy2", 32'(busy), 32'd0);

      for (int i = 0; i < 40; i++) begin
         do_op(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
